floo_id_dst_tracker: RTL

- Per-txnID outstanding-transaction tracker that implements the `NoRoB` ordering policy in the network interface.
- Sits between the AXI Ax channel (AW or AR) and the flit packer. It stalls a request whose txnID already has transactions outstanding to a different destination.
- Consumes the matching response handshakes (B or last R beat) to retire transactions.
- One instance is used per Ax/response channel pair.

---
 rtl/floo_pkg.sv | 17 +
 rtl/floo_id_dst_slot.sv | 56 +++++
 rtl/floo_id_dst_tracker.sv | 74 +++++++
 3 files changed

// File: rtl/floo_pkg.sv
// Shared FlooNoC network-interface types and helpers.
package floo_pkg;

    // Reorder policy for one response path. NoRoB avoids a reorder buffer
    // by stalling same-ID requests that target a different destination.
    typedef enum logic [1:0] {
        NormalRoB = 2'd0,
        SimpleRoB = 2'd1,
        NoRoB     = 2'd2
    } rob_type_e;

    // Width of a per-ID outstanding counter that must hold 0..max_txns.
    function automatic int unsigned id_cnt_width(int unsigned max_txns);
        return $clog2(max_txns + 1);
    endfunction

endpackage

// File: rtl/floo_id_dst_slot.sv
// One tracker slot: outstanding-transaction count and last destination for one txnID.
module floo_id_dst_slot
    import floo_pkg::*;
#(
    parameter int unsigned DstWidth = 8,
    parameter int unsigned CntWidth = 4,
    parameter int unsigned MaxTxns  = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                inc_i,
    input  logic                dec_i,
    input  logic                load_i,
    input  logic [DstWidth-1:0] dst_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic [DstWidth-1:0] dst_o
);

    logic [CntWidth-1:0] r_cnt;
    logic [DstWidth-1:0] r_dst;
    logic                w_decEff;

    // A retirement against an empty slot is ignored so the count never wraps.
    assign w_decEff = dec_i && (r_cnt != '0);

    // Count up on accept, down on retire, hold when both land together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_dst <= '0;
        end else begin
            if (inc_i && !w_decEff) begin
                r_cnt <= r_cnt + CntWidth'(1);
            end else if (!inc_i && w_decEff) begin
                r_cnt <= r_cnt - CntWidth'(1);
            end
            if (load_i) begin
                r_dst <= dst_i;
            end
        end
    end

    assign cnt_o = r_cnt;
    assign dst_o = r_dst;

`ifndef SYNTHESIS
    a_noUnderflow : assert property (@(posedge clk_i) disable iff (rst_i)
        dec_i |-> (r_cnt != '0))
        else $error("floo_id_dst_slot: response retired with no outstanding transaction");

    a_noOverflow : assert property (@(posedge clk_i) disable iff (rst_i)
        r_cnt <= CntWidth'(MaxTxns))
        else $error("floo_id_dst_slot: outstanding count above maximum");
`endif

endmodule

// File: rtl/floo_id_dst_tracker.sv
// Per-txnID outstanding tracker implementing the NoRoB ordering policy.
// Requests pass through combinationally unless their ID is busy toward another
// destination or already at the outstanding limit.
module floo_id_dst_tracker
    import floo_pkg::*;
#(
    parameter int unsigned IdWidth      = 4,
    parameter int unsigned DstWidth     = 8,
    parameter int unsigned MaxTxnsPerId = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                ax_valid_i,
    output logic                ax_ready_o,
    input  logic [IdWidth-1:0]  ax_id_i,
    input  logic [DstWidth-1:0] ax_dst_i,
    output logic                ax_valid_o,
    input  logic                ax_ready_i,
    input  logic                rsp_valid_i,
    input  logic                rsp_ready_i,
    input  logic [IdWidth-1:0]  rsp_id_i,
    output logic                busy_o
);

    localparam int unsigned NumIds   = 2 ** IdWidth;
    localparam int unsigned CntWidth = id_cnt_width(MaxTxnsPerId);

    logic [CntWidth-1:0] w_cnt    [NumIds];
    logic [DstWidth-1:0] w_dst    [NumIds];
    logic [NumIds-1:0]   w_inc;
    logic [NumIds-1:0]   w_dec;
    logic [NumIds-1:0]   w_nonZero;
    logic [CntWidth-1:0] w_selCnt;
    logic [DstWidth-1:0] w_selDst;
    logic                w_stall;
    logic                w_push;
    logic                w_pop;

    // Stall is judged on the state before any same-cycle retirement.
    assign w_selCnt = w_cnt[ax_id_i];
    assign w_selDst = w_dst[ax_id_i];
    assign w_stall  = ((w_selCnt != '0) && (w_selDst != ax_dst_i)) ||
                      (w_selCnt == CntWidth'(MaxTxnsPerId));

    assign ax_valid_o = ax_valid_i & ~w_stall;
    assign ax_ready_o = ax_ready_i & ~w_stall;

    assign w_push = ax_valid_i & ax_ready_i & ~w_stall;
    assign w_pop  = rsp_valid_i & rsp_ready_i;

    for (genvar gI = 0; gI < NumIds; gI++) begin : g_slot
        assign w_inc[gI]     = w_push && (ax_id_i == IdWidth'(gI));
        assign w_dec[gI]     = w_pop && (rsp_id_i == IdWidth'(gI));
        assign w_nonZero[gI] = (w_cnt[gI] != '0);

        floo_id_dst_slot #(
            .DstWidth (DstWidth),
            .CntWidth (CntWidth),
            .MaxTxns  (MaxTxnsPerId)
        ) u_slot (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .inc_i  (w_inc[gI]),
            .dec_i  (w_dec[gI]),
            .load_i (w_inc[gI]),
            .dst_i  (ax_dst_i),
            .cnt_o  (w_cnt[gI]),
            .dst_o  (w_dst[gI])
        );
    end

    assign busy_o = |w_nonZero;

endmodule
